// File: rtl/register_file_if.sv
`default_nettype none
// ============================================================================
// Module   : register_file_if
// Purpose  : Bundles the execute-stage register bus and the debug access port
//            of the AAP register file.
// Modports : master - execute stage / debugger side (drives addresses, data,
//                     strobes, stop and debug requests)
//            slave  - register file side (returns read data, carry, debug
//                     acknowledge and debug read data)
// Revision : 1.0 - initial release
// ============================================================================
interface register_file_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 6
);
  // Pipeline read ports
  logic [AW-1:0]    reg_rd1, reg_rd2, reg_rd3;
  logic [WIDTH-1:0] reg_rd1_out, reg_rd2_out, reg_rd3_out;
  // Pipeline write ports
  logic [AW-1:0]    reg_wr1, reg_wr2;
  logic [WIDTH-1:0] reg_wr1_data, reg_wr2_data;
  logic             reg_wr1_enable, reg_wr2_enable;
  // Carry flag
  logic             carrybit;
  logic             carrybit_wr;
  logic             carrybit_wr_enable;
  // Debug access port
  logic             stop;
  logic             dbg_req;
  logic             dbg_we;
  logic [6:0]       dbg_addr;
  logic [WIDTH-1:0] dbg_wdata;
  logic             dbg_ack;
  logic [WIDTH-1:0] dbg_rdata;

  modport master (
    output reg_rd1, reg_rd2, reg_rd3,
    input  reg_rd1_out, reg_rd2_out, reg_rd3_out,
    output reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data,
    output reg_wr1_enable, reg_wr2_enable,
    input  carrybit,
    output carrybit_wr, carrybit_wr_enable,
    output stop, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_ack, dbg_rdata
  );

  modport slave (
    input  reg_rd1, reg_rd2, reg_rd3,
    output reg_rd1_out, reg_rd2_out, reg_rd3_out,
    input  reg_wr1, reg_wr2, reg_wr1_data, reg_wr2_data,
    input  reg_wr1_enable, reg_wr2_enable,
    output carrybit,
    input  carrybit_wr, carrybit_wr_enable,
    input  stop, dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_ack, dbg_rdata
  );
endinterface
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Purpose  : AAP architectural register file: NREGS x WIDTH general registers
//            plus carry flag, three combinational read ports, two write ports
//            and a four-phase debug access port usable while the core is
//            halted.
// Ports    : clock - rising-edge clock
//            reset - asynchronous active-low reset
//            bus   - register_file_if.slave (pipeline + debug signals)
// Revision : 1.0 - initial release
// ============================================================================
module register_file #(
  parameter int NREGS = 64,
  parameter int WIDTH = 16
) (
  input  wire logic      clock,
  input  wire logic      reset,
  register_file_if.slave bus
);

  localparam int         AW            = $clog2(NREGS);
  // Debug address of the carry flag sits just past the last register.
  localparam logic [6:0] c_carry_addr  = 7'(NREGS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [NREGS];
  logic             carry_q;
  logic             dbg_we_q;
  logic [6:0]       dbg_addr_q;
  logic [WIDTH-1:0] dbg_wdata_q;
  logic             dbg_ack_q;
  logic [WIDTH-1:0] dbg_rdata_q;

  logic             w_dbg_in_range;
  logic             w_dbg_is_carry;
  logic             w_dbg_access;
  logic             w_dbg_wr_reg;
  logic             w_dbg_wr_carry;
  logic [WIDTH-1:0] w_dbg_rd_value;

  // --------------------------------------------------------------------------
  // Combinational read ports, no bypass of same-cycle writes
  // --------------------------------------------------------------------------
  assign bus.reg_rd1_out = regs_q[bus.reg_rd1];
  assign bus.reg_rd2_out = regs_q[bus.reg_rd2];
  assign bus.reg_rd3_out = regs_q[bus.reg_rd3];
  assign bus.carrybit    = carry_q;
  assign bus.dbg_ack     = dbg_ack_q;
  assign bus.dbg_rdata   = dbg_rdata_q;

  // --------------------------------------------------------------------------
  // Debug FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (bus.dbg_req && bus.stop) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_ACK;
      ST_ACK:    if (!bus.dbg_req) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign w_dbg_in_range = (dbg_addr_q < c_carry_addr);
  assign w_dbg_is_carry = (dbg_addr_q == c_carry_addr);
  assign w_dbg_access   = (state_q == ST_ACCESS);
  assign w_dbg_wr_reg   = w_dbg_access && dbg_we_q && w_dbg_in_range;
  assign w_dbg_wr_carry = w_dbg_access && dbg_we_q && w_dbg_is_carry;

  always_comb begin
    w_dbg_rd_value = '0;
    if (w_dbg_in_range)      w_dbg_rd_value = regs_q[dbg_addr_q[AW-1:0]];
    else if (w_dbg_is_carry) w_dbg_rd_value = {{(WIDTH-1){1'b0}}, carry_q};
  end

  // Request fields are captured once on entry so the requester may change
  // them freely after dbg_req is seen.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dbg_we_q    <= 1'b0;
      dbg_addr_q  <= '0;
      dbg_wdata_q <= '0;
      dbg_ack_q   <= 1'b0;
      dbg_rdata_q <= '0;
    end else begin
      if (state_q == ST_IDLE && bus.dbg_req && bus.stop) begin
        dbg_we_q    <= bus.dbg_we;
        dbg_addr_q  <= bus.dbg_addr;
        dbg_wdata_q <= bus.dbg_wdata;
      end
      if (w_dbg_access && !dbg_we_q) dbg_rdata_q <= w_dbg_rd_value;
      dbg_ack_q <= (state_d == ST_ACK);
    end
  end

  // --------------------------------------------------------------------------
  // Register array and carry. Statements are ordered lowest priority first so
  // the later non-blocking assignment wins: debug < wr2 < wr1.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (w_dbg_wr_reg)       regs_q[dbg_addr_q[AW-1:0]] <= dbg_wdata_q;
      if (bus.reg_wr2_enable) regs_q[bus.reg_wr2] <= bus.reg_wr2_data;
      if (bus.reg_wr1_enable) regs_q[bus.reg_wr1] <= bus.reg_wr1_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      carry_q <= 1'b0;
    end else begin
      if (w_dbg_wr_carry)         carry_q <= dbg_wdata_q[0];
      if (bus.carrybit_wr_enable) carry_q <= bus.carrybit_wr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_register_file
// Purpose  : Self-checking bench for register_file: directed stimulus, a
//            transaction-level reference model checked every cycle, and
//            hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_register_file;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  register_file_if #(.WIDTH(16), .AW(6)) bus ();

  register_file #(.NREGS(64), .WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: architectural state plus an abstract debug transaction
  // (pending access, then acknowledged until the request drops).
  // --------------------------------------------------------------------------
  logic [15:0] m_regs [64];
  logic        m_carry;
  int          m_phase;          // 0 none, 1 access pending, 2 acknowledged
  logic        m_we;
  int          m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_carry = 1'b0;
      m_phase = 0;
      m_rdata = 16'h0;
    end else begin
      if (m_phase == 1) begin
        if (!m_we)
          m_rdata = (m_addr < 64) ? m_regs[m_addr] : (m_addr == 64) ? {15'h0, m_carry} : 16'h0;
        else if (m_addr < 64) m_regs[m_addr] = m_wdata;
        else if (m_addr == 64) m_carry = m_wdata[0];
      end
      if (bus.reg_wr2_enable) m_regs[bus.reg_wr2] = bus.reg_wr2_data;
      if (bus.reg_wr1_enable) m_regs[bus.reg_wr1] = bus.reg_wr1_data;
      if (bus.carrybit_wr_enable) m_carry = bus.carrybit_wr;
      case (m_phase)
        0: if (bus.dbg_req && bus.stop) begin
             m_phase = 1; m_we = bus.dbg_we; m_addr = int'(bus.dbg_addr); m_wdata = bus.dbg_wdata;
           end
        1: m_phase = 2;
        default: if (!bus.dbg_req) m_phase = 0;
      endcase
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk($sformatf("model_rd1[%0d]", bus.reg_rd1), bus.reg_rd1_out, m_regs[bus.reg_rd1]);
      chk($sformatf("model_rd2[%0d]", bus.reg_rd2), bus.reg_rd2_out, m_regs[bus.reg_rd2]);
      chk($sformatf("model_rd3[%0d]", bus.reg_rd3), bus.reg_rd3_out, m_regs[bus.reg_rd3]);
      chk("model_carry", bus.carrybit, m_carry);
      chk("model_ack", bus.dbg_ack, (m_phase == 2));
      if (m_phase == 2) chk("model_rdata", bus.dbg_rdata, m_rdata);
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers: inputs change 2 time units after each rising edge.
  // --------------------------------------------------------------------------
  task automatic step();
    @(posedge clock);
    #2;
  endtask

  task automatic dbg_txn(input logic we, input logic [6:0] addr, input logic [15:0] wd,
                         output int edges, output logic [15:0] rd);
    bus.dbg_req = 1'b1; bus.dbg_we = we; bus.dbg_addr = addr; bus.dbg_wdata = wd;
    edges = 0;
    while (!bus.dbg_ack && edges < 20) begin
      step();
      edges++;
    end
    if (!bus.dbg_ack) chk("dbg_ack_timeout", 0, 1);
    rd = bus.dbg_rdata;
    bus.dbg_req = 1'b0;
    step();
    chk("dbg_ack_clear", bus.dbg_ack, 0);
    step();
  endtask

  int          edges;
  logic [15:0] rd;

  initial begin
    bus.reg_rd1 = 0; bus.reg_rd2 = 0; bus.reg_rd3 = 0;
    bus.reg_wr1 = 0; bus.reg_wr2 = 0; bus.reg_wr1_data = 0; bus.reg_wr2_data = 0;
    bus.reg_wr1_enable = 0; bus.reg_wr2_enable = 0;
    bus.carrybit_wr = 0; bus.carrybit_wr_enable = 0;
    bus.stop = 0; bus.dbg_req = 0; bus.dbg_we = 0; bus.dbg_addr = 0; bus.dbg_wdata = 0;
    step(); step();
    chk("reset_ack", bus.dbg_ack, 0);
    chk("reset_rdata", bus.dbg_rdata, 0);
    chk("reset_carry", bus.carrybit, 0);
    reset = 1'b1;
    step();

    // Write r5 via wr1: invisible before the edge, visible after
    bus.reg_rd1 = 5; bus.reg_wr1 = 5; bus.reg_wr1_data = 16'h1234; bus.reg_wr1_enable = 1;
    #1 chk("r5_before_edge", bus.reg_rd1_out, 16'h0);
    step();
    bus.reg_wr1_enable = 0;
    #1 chk("r5_after_edge", bus.reg_rd1_out, 16'h1234);
    for (int i = 0; i < 64; i += 3) begin
      bus.reg_rd1 = 6'(i); bus.reg_rd2 = 6'(i + 1); bus.reg_rd3 = 6'(i + 2);
      step();
    end

    // Collision: wr1 wins; distinct addresses both land
    bus.reg_wr1 = 7; bus.reg_wr1_data = 16'hAAAA; bus.reg_wr1_enable = 1;
    bus.reg_wr2 = 7; bus.reg_wr2_data = 16'h5555; bus.reg_wr2_enable = 1;
    step();
    bus.reg_wr1 = 8; bus.reg_wr1_data = 16'h0001;
    bus.reg_wr2 = 9; bus.reg_wr2_data = 16'h0002;
    step();
    bus.reg_wr1_enable = 0; bus.reg_wr2_enable = 0;
    bus.reg_rd1 = 7; bus.reg_rd2 = 8; bus.reg_rd3 = 9;
    #1;
    chk("collide_r7", bus.reg_rd1_out, 16'hAAAA);
    chk("r8", bus.reg_rd2_out, 16'h0001);
    chk("r9", bus.reg_rd3_out, 16'h0002);

    // Carry write and hold
    bus.carrybit_wr = 1; bus.carrybit_wr_enable = 1;
    step();
    bus.carrybit_wr = 0; bus.carrybit_wr_enable = 0;
    #1 chk("carry_set", bus.carrybit, 1);
    step(); step();
    #1 chk("carry_hold", bus.carrybit, 1);

    // Debug write then read back
    bus.stop = 1;
    dbg_txn(1, 7'd3, 16'hBEEF, edges, rd);
    chk("dbg_wr_edges", edges, 2);
    dbg_txn(0, 7'd3, 16'h0000, edges, rd);
    chk("dbg_rd_edges", edges, 2);
    chk("dbg_rd_r3", rd, 16'hBEEF);
    bus.reg_rd1 = 3;
    #1 chk("r3_port", bus.reg_rd1_out, 16'hBEEF);
    dbg_txn(0, 7'd64, 16'h0000, edges, rd);
    chk("dbg_rd_carry", rd, 16'h0001);
    dbg_txn(0, 7'd100, 16'h0000, edges, rd);
    chk("dbg_rd_unmapped", rd, 16'h0000);
    chk("dbg_unmapped_edges", edges, 2);
    dbg_txn(1, 7'd127, 16'hFFFF, edges, rd);
    chk("dbg_wr_unmapped_edges", edges, 2);

    // Request held off while not halted
    bus.stop = 0; bus.dbg_req = 1; bus.dbg_we = 0; bus.dbg_addr = 7'd5;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_off_ack", bus.dbg_ack, 0);
    end
    bus.stop = 1;
    step();
    chk("stop_e0_ack", bus.dbg_ack, 0);
    step();
    chk("stop_e1_ack", bus.dbg_ack, 1);
    chk("stop_rdata_r5", bus.dbg_rdata, 16'h1234);
    bus.dbg_req = 0;
    step();
    chk("drop_req_ack", bus.dbg_ack, 0);
    step();

    // Debug write loses to wr1 at the ACCESS edge, still acknowledged
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 7'd10; bus.dbg_wdata = 16'h1111;
    step();
    bus.reg_wr1 = 10; bus.reg_wr1_data = 16'h2222; bus.reg_wr1_enable = 1;
    bus.stop = 0;  // halt ends mid-transaction; access must still complete
    step();
    bus.reg_wr1_enable = 0;
    bus.reg_rd1 = 10;
    #1;
    chk("collide_dbg_ack", bus.dbg_ack, 1);
    chk("collide_r10", bus.reg_rd1_out, 16'h2222);
    bus.dbg_req = 0;
    step(); step();
    bus.stop = 1;

    // Debug carry write loses to carrybit_wr_enable
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 7'd64; bus.dbg_wdata = 16'h0000;
    step();
    bus.carrybit_wr = 1; bus.carrybit_wr_enable = 1;
    step();
    bus.carrybit_wr_enable = 0; bus.carrybit_wr = 0;
    #1 chk("carry_dbg_loses", bus.carrybit, 1);
    bus.dbg_req = 0;
    step(); step();

    // Reset during ACCESS discards the debug write and never acknowledges
    bus.dbg_req = 1; bus.dbg_we = 1; bus.dbg_addr = 7'd11; bus.dbg_wdata = 16'h7777;
    step();
    reset = 1'b0; bus.dbg_req = 0;
    #1;
    chk("rst_access_ack", bus.dbg_ack, 0);
    chk("rst_carry", bus.carrybit, 0);
    reset = 1'b1;
    bus.reg_rd1 = 11; bus.reg_rd2 = 7; bus.reg_rd3 = 5;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_no_ack", bus.dbg_ack, 0);
    end
    chk("rst_r11", bus.reg_rd1_out, 16'h0);
    chk("rst_r7", bus.reg_rd2_out, 16'h0);
    // FSM back in IDLE: a fresh request is served with normal latency
    dbg_txn(0, 7'd64, 16'h0000, edges, rd);
    chk("post_rst_edges", edges, 2);
    chk("post_rst_carry", rd, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
